// File: rtl/ad7606x_pif_sequencer_pkg.sv
// Shared types and widths for the AD7606x parallel-interface sequencer.
package ad7606x_pif_sequencer_pkg;

    localparam int CH_W   = 5;
    localparam int DATA_W = 16;
    localparam int CNT_W  = 16;

    typedef enum logic [2:0] {
        IDLE,
        CNVST,
        WAIT_BUSY_HI,
        WAIT_BUSY_LO,
        RD_LOW,
        RD_HIGH
    } state_t;

endpackage

// File: rtl/ad7606x_pif_sequencer_if.sv
// ADC pin bundle plus the captured-word stream towards the packer.
interface ad7606x_pif_sequencer_if;

    logic                                          rx_busy;
    logic [ad7606x_pif_sequencer_pkg::DATA_W-1:0]  rx_db_i;
    logic                                          rx_cnvst_n;
    logic                                          rx_cs_n;
    logic                                          rx_rd_n;
    logic                                          rx_wr_n;
    logic                                          rx_db_t;
    logic [ad7606x_pif_sequencer_pkg::DATA_W-1:0]  adc_data;
    logic                                          adc_valid;
    logic [ad7606x_pif_sequencer_pkg::CH_W-1:0]    adc_ch;
    logic                                          first_data;

    modport master (
        input  rx_busy, rx_db_i,
        output rx_cnvst_n, rx_cs_n, rx_rd_n, rx_wr_n, rx_db_t,
        output adc_data, adc_valid, adc_ch, first_data
    );

    modport slave (
        output rx_busy, rx_db_i,
        input  rx_cnvst_n, rx_cs_n, rx_rd_n, rx_wr_n, rx_db_t,
        input  adc_data, adc_valid, adc_ch, first_data
    );

endinterface

// File: rtl/ad7606x_pif_sequencer_busy_sync.sv
// Two-flop synchronizer for the asynchronous BUSY pin; 2-cycle latency.
module ad7606x_pif_sequencer_busy_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            dout <= 1'b0;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/ad7606x_pif_sequencer.sv
// One AD7606x conversion per conv_start: CNVST_N pulse, BUSY handshake, then CS_N/RD_N word reads.
// Captured words appear one cycle after the last RD_N-low cycle; no downstream backpressure.
module ad7606x_pif_sequencer
    import ad7606x_pif_sequencer_pkg::*;
#(
    parameter int NUM_CH      = 8,
    parameter int CNVST_CYC   = 4,
    parameter int RD_LOW_CYC  = 3,
    parameter int RD_HIGH_CYC = 2,
    parameter int BUSY_TO_CYC = 4096
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            conv_start,
    input  logic                            status_en,
    ad7606x_pif_sequencer_if.master         pif,
    output logic                            seq_active,
    output logic                            overrun,
    output logic                            busy_timeout
);

    localparam logic [CNT_W-1:0] CNV_LD = CNT_W'(CNVST_CYC - 1);
    localparam logic [CNT_W-1:0] TO_LD  = CNT_W'(BUSY_TO_CYC - 1);
    localparam logic [CNT_W-1:0] RDL_LD = CNT_W'(RD_LOW_CYC - 1);
    localparam logic [CNT_W-1:0] RDH_LD = CNT_W'(RD_HIGH_CYC - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [CH_W-1:0]   n;
    logic              st_lat;
    logic              busy_s;
    logic              is_last;

    ad7606x_pif_sequencer_busy_sync u_busy_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (pif.rx_busy),
        .dout (busy_s)
    );

    assign is_last     = (n == (st_lat ? CH_W'(NUM_CH) : CH_W'(NUM_CH - 1)));
    assign pif.rx_wr_n = 1'b1;
    assign pif.rx_db_t = 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            n              <= '0;
            st_lat         <= 1'b0;
            pif.rx_cnvst_n <= 1'b1;
            pif.rx_cs_n    <= 1'b1;
            pif.rx_rd_n    <= 1'b1;
            pif.adc_data   <= '0;
            pif.adc_valid  <= 1'b0;
            pif.adc_ch     <= '0;
            pif.first_data <= 1'b0;
            seq_active     <= 1'b0;
            overrun        <= 1'b0;
            busy_timeout   <= 1'b0;
        end else begin
            pif.adc_valid  <= 1'b0;
            pif.first_data <= 1'b0;
            busy_timeout   <= 1'b0;
            // The cycle that returns to IDLE still counts as busy for new requests.
            overrun        <= conv_start && (state != IDLE);
            case (state)
                IDLE: begin
                    if (conv_start) begin
                        state          <= CNVST;
                        pif.rx_cnvst_n <= 1'b0;
                        cnt            <= CNV_LD;
                        n              <= '0;
                        st_lat         <= status_en;
                        seq_active     <= 1'b1;
                    end
                end
                CNVST: begin
                    if (cnt == '0) begin
                        pif.rx_cnvst_n <= 1'b1;
                        cnt            <= TO_LD;
                        state          <= WAIT_BUSY_HI;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                WAIT_BUSY_HI, WAIT_BUSY_LO: begin
                    // One timeout window covers both BUSY edges.
                    if (cnt == '0) begin
                        busy_timeout <= 1'b1;
                        seq_active   <= 1'b0;
                        state        <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                        if (state == WAIT_BUSY_HI && busy_s) begin
                            state <= WAIT_BUSY_LO;
                        end else if (state == WAIT_BUSY_LO && !busy_s) begin
                            state       <= RD_LOW;
                            pif.rx_cs_n <= 1'b0;
                            pif.rx_rd_n <= 1'b0;
                            cnt         <= RDL_LD;
                        end
                    end
                end
                RD_LOW: begin
                    if (cnt == '0) begin
                        pif.adc_data   <= pif.rx_db_i;
                        pif.adc_valid  <= 1'b1;
                        pif.adc_ch     <= n;
                        pif.first_data <= (n == '0);
                        pif.rx_rd_n    <= 1'b1;
                        if (is_last) begin
                            pif.rx_cs_n <= 1'b1;
                            seq_active  <= 1'b0;
                            state       <= IDLE;
                        end else begin
                            cnt   <= RDH_LD;
                            state <= RD_HIGH;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RD_HIGH: begin
                    if (cnt == '0) begin
                        n           <= n + 1'b1;
                        pif.rx_rd_n <= 1'b0;
                        cnt         <= RDL_LD;
                        state       <= RD_LOW;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ad7606x_pif_sequencer.sv
// Directed bench: ADC BUSY/data model, pin-timing monitor and table-driven conversion checks.
module tb_ad7606x_pif_sequencer;

    logic clk;
    logic rst;
    logic conv_start;
    logic status_en;
    logic seq_active;
    logic overrun;
    logic busy_timeout;

    ad7606x_pif_sequencer_if ifc ();

    ad7606x_pif_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .conv_start   (conv_start),
        .status_en    (status_en),
        .pif          (ifc),
        .seq_active   (seq_active),
        .overrun      (overrun),
        .busy_timeout (busy_timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int pass_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // ADC model: BUSY high 10..29 cycles after CNVST_N rise; DB = 0xA000 + word index.
    logic busy_en = 1'b0;
    initial begin
        int   bt;
        int   widx;
        logic pc;
        logic pr;
        bt = -1; widx = 0; pc = 1'b1; pr = 1'b1;
        ifc.rx_busy = 1'b0;
        ifc.rx_db_i = 16'h0;
        forever begin
            @(negedge clk);
            if (busy_en && ifc.rx_cnvst_n && !pc) bt = 0;
            else if (bt >= 0) bt++;
            if (bt >= 30) bt = -1;
            ifc.rx_busy = (bt >= 10);
            if (!ifc.rx_cnvst_n) widx = 0;
            if (!ifc.rx_rd_n && pr) begin
                ifc.rx_db_i = 16'hA000 + 16'(widx);
                widx++;
            end
            pc = ifc.rx_cnvst_n;
            pr = ifc.rx_rd_n;
        end
    end

    // Monitor, sampled 1 time unit after each rising edge.
    logic clr = 1'b0;
    int nvalid, first_err, cnv_run, cnv_w, cnv_cnt, since_rise;
    int rd_falls, lo_run, lo_min, lo_max, hi_run, hi_min, hi_max;
    int cs_run, cs_w, ovr_cnt, ovr_run, ovr_wmax, to_cnt, to_at, const_err;
    int cap_data [32];
    int cap_ch   [32];
    logic p_cnv = 1'b1, p_rd = 1'b1, p_cs = 1'b1, p_ovr = 1'b0;

    always @(posedge clk) begin
        #1;
        if (clr) begin
            nvalid = 0; first_err = 0; cnv_run = 0; cnv_w = 0; cnv_cnt = 0; since_rise = 0;
            rd_falls = 0; lo_run = 0; lo_min = 999; lo_max = 0; hi_run = 0; hi_min = 999; hi_max = 0;
            cs_run = 0; cs_w = 0; ovr_cnt = 0; ovr_run = 0; ovr_wmax = 0; to_cnt = 0; to_at = 0;
            const_err = 0;
        end else begin
            if (ifc.adc_valid) begin
                if (nvalid < 32) begin
                    cap_data[nvalid] = int'(ifc.adc_data);
                    cap_ch[nvalid]   = int'(ifc.adc_ch);
                end
                nvalid++;
            end
            if (ifc.first_data != (ifc.adc_valid && ifc.adc_ch == 5'd0)) first_err++;
            if (!ifc.rx_cnvst_n) begin
                if (p_cnv) cnv_cnt++;
                cnv_run++;
            end else if (!p_cnv) begin
                cnv_w = cnv_run; cnv_run = 0; since_rise = 0;
            end else begin
                since_rise++;
            end
            if (!ifc.rx_rd_n) begin
                if (p_rd) begin
                    rd_falls++;
                    if (hi_run > 0) begin
                        if (hi_run < hi_min) hi_min = hi_run;
                        if (hi_run > hi_max) hi_max = hi_run;
                    end
                    hi_run = 0;
                end
                lo_run++;
            end else begin
                if (!p_rd) begin
                    if (lo_run < lo_min) lo_min = lo_run;
                    if (lo_run > lo_max) lo_max = lo_run;
                    lo_run = 0;
                end
                if (!ifc.rx_cs_n) hi_run++;
            end
            if (!ifc.rx_cs_n) cs_run++;
            else if (!p_cs) begin cs_w = cs_run; cs_run = 0; end
            if (overrun) begin
                if (!p_ovr) ovr_cnt++;
                ovr_run++;
                if (ovr_run > ovr_wmax) ovr_wmax = ovr_run;
            end else begin
                ovr_run = 0;
            end
            if (busy_timeout) begin to_cnt++; to_at = since_rise; end
            if (ifc.rx_wr_n !== 1'b1 || ifc.rx_db_t !== 1'b1) const_err++;
        end
        p_cnv = ifc.rx_cnvst_n; p_rd = ifc.rx_rd_n; p_cs = ifc.rx_cs_n; p_ovr = overrun;
    end

    function automatic int outs_vec();
        return int'({ifc.rx_cnvst_n, ifc.rx_cs_n, ifc.rx_rd_n, ifc.rx_wr_n, ifc.rx_db_t,
                     ifc.adc_valid, ifc.first_data, seq_active, overrun, busy_timeout,
                     ifc.adc_ch, ifc.adc_data});
    endfunction

    task automatic clear_stats();
        @(negedge clk); clr = 1'b1;
        @(negedge clk); @(negedge clk); clr = 1'b0;
    endtask

    task automatic pulse_start(input logic se);
        @(negedge clk); status_en = se; conv_start = 1'b1;
        @(negedge clk); conv_start = 1'b0; status_en = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int i;
        i = 0;
        while (seq_active && i < 6000) begin @(negedge clk); i++; end
        check(name, int'(seq_active), 0);
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_rd_falls(input int target);
        int i;
        i = 0;
        while (rd_falls < target && i < 200) begin @(negedge clk); i++; end
        check("rd_fall_reached", rd_falls, target);
    endtask

    task automatic check_words(input string tag, input int words);
        check({tag, "_words"}, nvalid, words);
        for (int i = 0; i < words && i < nvalid && i < 32; i++) begin
            check($sformatf("%s_data%0d", tag, i), cap_data[i], 32'hA000 + i);
            check($sformatf("%s_ch%0d", tag, i), cap_ch[i], i);
        end
        check({tag, "_first_data"}, first_err, 0);
    endtask

    typedef struct {
        logic se;
        logic ben;
        int   words;
        int   cs_w;
        int   tos;
    } vec_t;

    vec_t vecs [5];
    int   reset_vec;

    initial begin
        reset_vec  = {5'b11111, 26'd0};
        vecs[0] = '{se: 1'b0, ben: 1'b1, words: 8, cs_w: 38, tos: 0};
        vecs[1] = '{se: 1'b1, ben: 1'b1, words: 9, cs_w: 43, tos: 0};
        vecs[2] = '{se: 1'b0, ben: 1'b0, words: 0, cs_w: 0,  tos: 1};
        vecs[3] = '{se: 1'b1, ben: 1'b1, words: 9, cs_w: 43, tos: 0};
        vecs[4] = '{se: 1'b0, ben: 1'b1, words: 8, cs_w: 38, tos: 0};

        rst = 1'b1; conv_start = 1'b0; status_en = 1'b0;
        repeat (4) @(negedge clk);
        check("reset_outputs", outs_vec(), reset_vec);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_outputs", outs_vec(), reset_vec);

        for (int v = 0; v < 5; v++) begin
            string tag;
            tag = $sformatf("vec%0d", v);
            clear_stats();
            busy_en = vecs[v].ben;
            pulse_start(vecs[v].se);
            wait_idle({tag, "_done"});
            check_words(tag, vecs[v].words);
            check({tag, "_cnvst_w"}, cnv_w, 4);
            check({tag, "_cnvst_cnt"}, cnv_cnt, 1);
            check({tag, "_rd_falls"}, rd_falls, vecs[v].words);
            check({tag, "_cs_low_w"}, cs_w, vecs[v].cs_w);
            check({tag, "_timeouts"}, to_cnt, vecs[v].tos);
            check({tag, "_overruns"}, ovr_cnt, 0);
            check({tag, "_wr_db_t"}, const_err, 0);
            if (vecs[v].tos > 0) check({tag, "_timeout_at"}, to_at, 4096);
            if (vecs[v].words > 1) begin
                check({tag, "_rd_lo_min"}, lo_min, 3);
                check({tag, "_rd_lo_max"}, lo_max, 3);
                check({tag, "_rd_hi_min"}, hi_min, 2);
                check({tag, "_rd_hi_max"}, hi_max, 2);
            end
        end

        // Request arriving while ch3 is being read.
        clear_stats();
        busy_en = 1'b1;
        pulse_start(1'b0);
        wait_rd_falls(4);
        pulse_start(1'b1);
        wait_idle("ovr_done");
        check("ovr_pulses", ovr_cnt, 1);
        check("ovr_width", ovr_wmax, 1);
        check("ovr_cnvst_cnt", cnv_cnt, 1);
        check("ovr_rd_falls", rd_falls, 8);
        check_words("ovr", 8);

        // Reset in the middle of the ch5 read.
        clear_stats();
        pulse_start(1'b0);
        wait_rd_falls(6);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_outputs", outs_vec(), reset_vec);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("midrst_words", nvalid, 5);
        check("midrst_timeouts", to_cnt, 0);
        check("midrst_overruns", ovr_cnt, 0);
        check("midrst_idle_outs", outs_vec(), {5'b11111, 26'd0} | int'({ifc.adc_ch, ifc.adc_data}));

        clear_stats();
        pulse_start(1'b0);
        wait_idle("recover_done");
        check_words("recover", 8);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

endmodule
